ram_responder: RTL and testbench

Memory-side responder for the processor's RAM request bus: accepts one read or write request per handshake on the same rw/address/data signalling the memory controller drives toward program and video RAM, performs the access on an internal single-port array after a configurable number of wait states, and returns a one-cycle response. One instance sits behind the program-RAM port and one behind the video-RAM port.

---
 rtl/ram_responder.sv | 175 +++++++++++++++++
 tb/tb_ram_responder.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// ram_responder: memory-side responder for the RAM request bus.
//
// Accepts one read or write per req_valid/req_ready handshake, performs the
// access on an internal single-port array after WAIT_STATES extra cycles, and
// returns a one-cycle rsp_valid strobe with rsp_data/rsp_fault.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   req_valid    request present
//   req_ready    responder can accept a request this cycle (registered)
//   ram_rw       0 = read, 1 = write
//   ram_address  word address
//   ram_data     write data (ignored for reads)
//   rsp_valid    one-cycle response strobe
//   rsp_data     read data, or echoed write data for writes
//   rsp_fault    address out of range (qualified by rsp_valid)
//
// Optional feature: define RAM_CLEAR_ON_RESET_EN to zero the whole array after
// every reset (one word per cycle, req_ready held low until done).

module ram_responder #(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned DEPTH_LOG2    = 12,  // must be <= ADDRESS_WIDTH
    parameter int unsigned WAIT_STATES   = 1    // 0..15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     ram_rw,
    input  logic [ADDRESS_WIDTH-1:0] ram_address,
    input  logic [DATA_WIDTH-1:0]    ram_data,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic                     rsp_fault
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StRespond
`ifdef RAM_CLEAR_ON_RESET_EN
        , StClear
`endif
    } state_e;

    state_e                   state_q;
    logic                     req_ready_q;
    logic                     rsp_valid_q;
    logic [DATA_WIDTH-1:0]    rsp_data_q;
    logic                     rsp_fault_q;
    logic                     rw_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [3:0]               wait_cnt_q;
`ifdef RAM_CLEAR_ON_RESET_EN
    logic [DEPTH_LOG2-1:0]    clr_cnt_q;
`endif

    logic [DATA_WIDTH-1:0]    mem [Depth];

    logic [DEPTH_LOG2-1:0]    addr_idx;
    logic                     out_of_range;
    logic                     commit;
    logic                     mem_we;
    logic [DEPTH_LOG2-1:0]    mem_waddr;
    logic [DATA_WIDTH-1:0]    mem_wdata;

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_fault = rsp_fault_q;

    assign addr_idx = addr_q[DEPTH_LOG2-1:0];
    // Any latched bit at or above DEPTH_LOG2 faults; there is no aliasing.
    assign out_of_range = |(addr_q >> DEPTH_LOG2);
    assign commit = (state_q == StAccess) && (wait_cnt_q == 4'd0);

    // Array write port. Gated by !rst so an access still pending when reset
    // arrives never reaches the array.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_idx;
        mem_wdata = data_q;
        if (!rst) begin
            if (commit && rw_q && !out_of_range) begin
                mem_we = 1'b1;
            end
`ifdef RAM_CLEAR_ON_RESET_EN
            if (state_q == StClear) begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef RAM_CLEAR_ON_RESET_EN
            state_q   <= StClear;
            clr_cnt_q <= '0;
`else
            state_q   <= StIdle;
`endif
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_fault_q <= 1'b0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            wait_cnt_q  <= 4'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle, StRespond: begin
                    if (req_valid && req_ready_q) begin
                        state_q     <= StAccess;
                        req_ready_q <= 1'b0;
                        rw_q        <= ram_rw;
                        addr_q      <= ram_address;
                        data_q      <= ram_data;
                        wait_cnt_q  <= 4'(WAIT_STATES);
                    end else begin
                        state_q     <= StIdle;
                        req_ready_q <= 1'b1;
                    end
                end
                StAccess: begin
                    if (wait_cnt_q != 4'd0) begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end else begin
                        state_q     <= StRespond;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_fault_q <= out_of_range;
                        if (rw_q) begin
                            rsp_data_q <= data_q;
                        end else if (out_of_range) begin
                            rsp_data_q <= '0;
                        end else begin
                            rsp_data_q <= mem[addr_idx];
                        end
                    end
                end
`ifdef RAM_CLEAR_ON_RESET_EN
                StClear: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (&clr_cnt_q) begin
                        state_q     <= StIdle;
                        req_ready_q <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder. Four instances share clk/rst:
//   0: DEPTH_LOG2=12, WAIT_STATES=1 (main, checked against a word-level model)
//   1: WAIT_STATES=0   2: WAIT_STATES=15   3: DEPTH_LOG2=4, WAIT_STATES=1

module tb_ram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid   [4];
    logic        ram_rw      [4];
    logic [15:0] ram_address [4];
    logic [15:0] ram_data    [4];
    logic        req_ready   [4];
    logic        rsp_valid   [4];
    logic [15:0] rsp_data    [4];
    logic        rsp_fault   [4];

    int checks = 0;
    int errors = 0;

    // Word-level model of instance 0: address -> last value written.
    logic [15:0] model0 [int];

    always #5 clk = ~clk;

    ram_responder #(.ADDRESS_WIDTH(16), .DATA_WIDTH(16), .DEPTH_LOG2(12), .WAIT_STATES(1)) u_dut_w1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .ram_rw(ram_rw[0]), .ram_address(ram_address[0]), .ram_data(ram_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .rsp_fault(rsp_fault[0]));

    ram_responder #(.ADDRESS_WIDTH(16), .DATA_WIDTH(16), .DEPTH_LOG2(12), .WAIT_STATES(0)) u_dut_w0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .ram_rw(ram_rw[1]), .ram_address(ram_address[1]), .ram_data(ram_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .rsp_fault(rsp_fault[1]));

    ram_responder #(.ADDRESS_WIDTH(16), .DATA_WIDTH(16), .DEPTH_LOG2(12), .WAIT_STATES(15)) u_dut_w15 (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .ram_rw(ram_rw[2]), .ram_address(ram_address[2]), .ram_data(ram_data[2]),
        .rsp_valid(rsp_valid[2]), .rsp_data(rsp_data[2]), .rsp_fault(rsp_fault[2]));

    ram_responder #(.ADDRESS_WIDTH(16), .DATA_WIDTH(16), .DEPTH_LOG2(4), .WAIT_STATES(1)) u_dut_small (
        .clk(clk), .rst(rst), .req_valid(req_valid[3]), .req_ready(req_ready[3]),
        .ram_rw(ram_rw[3]), .ram_address(ram_address[3]), .ram_data(ram_data[3]),
        .rsp_valid(rsp_valid[3]), .rsp_data(rsp_data[3]), .rsp_fault(rsp_fault[3]));

    function automatic logic [15:0] model_read(input logic [15:0] a);
        if (model0.exists(int'(a))) return model0[int'(a)];
        return 16'h0000;
    endfunction

    // Issue one request on instance sel and check latency, ready, data and fault.
    task automatic do_req(input int sel, input logic rw, input logic [15:0] addr,
                          input logic [15:0] data, input int exp_lat,
                          input logic [15:0] exp_data, input bit chk_data,
                          input logic exp_fault, input string name,
                          output logic [15:0] got_data);
        bit acc;
        bit got;
        int n;
        ram_rw[sel]      = rw;
        ram_address[sel] = addr;
        ram_data[sel]    = data;
        req_valid[sel]   = 1'b1;
        acc = 1'b0;
        got_data = 'x;
        for (int i = 0; i < 200 && !acc; i++) begin
            acc = (req_ready[sel] === 1'b1);
            @(posedge clk);
            #1;
        end
        req_valid[sel] = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL %s accept: req_ready never high within 200 cycles", name);
            return;
        end
        got = 1'b0;
        n = 0;
        while (!got && n < 64) begin
            checks++;
            if (req_ready[sel] !== 1'b0) begin
                errors++;
                $display("FAIL %s ready_in_access: req_ready=%b want 0", name, req_ready[sel]);
            end
            @(posedge clk);
            #1;
            n++;
            got = (rsp_valid[sel] === 1'b1);
        end
        checks++;
        if (!got || n != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles (seen=%0d) want %0d", name, n, got, exp_lat);
        end
        got_data = rsp_data[sel];
        if (chk_data) begin
            checks++;
            if (rsp_data[sel] !== exp_data) begin
                errors++;
                $display("FAIL %s data: got %h want %h", name, rsp_data[sel], exp_data);
            end
        end
        checks++;
        if (rsp_fault[sel] !== exp_fault) begin
            errors++;
            $display("FAIL %s fault: got %b want %b", name, rsp_fault[sel], exp_fault);
        end
        checks++;
        if (req_ready[sel] !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_in_respond: got %b want 1", name, req_ready[sel]);
        end
        // One cycle later the strobe drops but data/fault hold.
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid[sel] !== 1'b0 || rsp_fault[sel] !== exp_fault ||
            (chk_data && rsp_data[sel] !== exp_data)) begin
            errors++;
            $display("FAIL %s hold: valid=%b data=%h fault=%b want valid=0 data=%h fault=%b",
                     name, rsp_valid[sel], rsp_data[sel], rsp_fault[sel], exp_data, exp_fault);
        end
    endtask

    // Request on instance 0 with the expectation taken from the model.
    task automatic op0(input logic rw, input logic [15:0] addr, input logic [15:0] data,
                       input string name, output logic [15:0] got);
        logic        oor;
        logic [15:0] exp;
        oor = (addr[15:12] != 4'd0);
        exp = rw ? data : (oor ? 16'h0000 : model_read(addr));
        do_req(0, rw, addr, data, 2, exp, !(rw && oor), oor, name, got);
        if (rw && !oor) model0[int'(addr)] = data;
    endtask

    task automatic release_reset();
`ifdef RAM_CLEAR_ON_RESET_EN
        int n_small;
        bit all_rdy;
        n_small = -1;
        all_rdy = 1'b0;
        rst = 1'b0;
        model0.delete();
        for (int n = 1; n <= 5000 && !all_rdy; n++) begin
            @(posedge clk);
            #1;
            if (req_ready[3] === 1'b1 && n_small < 0) n_small = n;
            all_rdy = (req_ready[0] === 1'b1) && (req_ready[1] === 1'b1) &&
                      (req_ready[2] === 1'b1) && (req_ready[3] === 1'b1);
        end
        checks++;
        if (n_small != 16) begin
            errors++;
            $display("FAIL clear_ready_delay: ready rose after %0d cycles want 16", n_small);
        end
        checks++;
        if (!all_rdy) begin
            errors++;
            $display("FAIL clear_done: req_ready not high on all instances within 5000 cycles");
        end
`else
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (req_ready[i] !== 1'b1) begin
                errors++;
                $display("FAIL ready_after_reset[%0d]: got %b want 1", i, req_ready[i]);
            end
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (req_ready[i] !== 1'b0 || rsp_valid[i] !== 1'b0 ||
                rsp_data[i] !== 16'h0000 || rsp_fault[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_values[%0d]: ready=%b valid=%b data=%h fault=%b want 0/0/0000/0",
                         i, req_ready[i], rsp_valid[i], rsp_data[i], rsp_fault[i]);
            end
        end
        release_reset();
    endtask

    task automatic test_write_read();
        logic [15:0] g;
        op0(1'b1, 16'h0123, 16'hBEEF, "wr_0123", g);
        op0(1'b0, 16'h0123, 16'h0000, "rd_0123", g);
    endtask

    task automatic test_back_to_back();
        logic [15:0] g;
        logic [15:0] addrs [3];
        int          rc [$];
        logic [15:0] rd [$];
        int          exp_c [3];
        int          idx;
        bit          acc;
        addrs[0] = 16'h0010; addrs[1] = 16'h0011; addrs[2] = 16'h0012;
        exp_c[0] = 3; exp_c[1] = 6; exp_c[2] = 9;
        for (int k = 0; k < 3; k++) op0(1'b1, addrs[k], 16'(k + 1), "b2b_preload", g);
        idx = 0;
        ram_rw[0] = 1'b0;
        ram_address[0] = addrs[0];
        req_valid[0] = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            acc = (req_ready[0] === 1'b1) && req_valid[0];
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < 3) ram_address[0] = addrs[idx];
                else req_valid[0] = 1'b0;
            end
            if (rsp_valid[0] === 1'b1) begin
                rc.push_back(cyc);
                rd.push_back(rsp_data[0]);
            end
        end
        req_valid[0] = 1'b0;
        checks++;
        if (rc.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d responses want 3", rc.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rc[k] != exp_c[k] || rd[k] !== 16'(k + 1)) begin
                    errors++;
                    $display("FAIL b2b_rsp%0d: cycle %0d data %h want cycle %0d data %h",
                             k, rc[k], rd[k], exp_c[k], 16'(k + 1));
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [15:0] g;
        op0(1'b1, 16'h0000, 16'hAAAA, "oor_preload", g);
        op0(1'b1, 16'h1000, 16'h5555, "oor_wr_1000", g);
        op0(1'b0, 16'h1000, 16'h0000, "oor_rd_1000", g);
        op0(1'b0, 16'h0000, 16'h0000, "oor_rd_0000", g);
    endtask

    task automatic test_random();
        logic [15:0] g;
        logic [15:0] a;
        for (int k = 0; k < 32; k++) op0(1'b1, 16'(k), 16'($urandom), "rand_preload", g);
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 7) == 0) a = {4'($urandom_range(1, 15)), 12'($urandom)};
            else a = 16'($urandom_range(0, 31));
            op0(1'($urandom_range(0, 1)), a, 16'($urandom), "rand_op", g);
        end
    endtask

    task automatic test_wait_states();
        logic [15:0] g;
        logic [15:0] d0;
        logic [15:0] d15;
        d0  = 16'($urandom);
        d15 = 16'($urandom);
        do_req(1, 1'b1, 16'h0200, d0, 1, d0, 1'b1, 1'b0, "w0_wr", g);
        do_req(1, 1'b0, 16'h0200, 16'h0000, 1, d0, 1'b1, 1'b0, "w0_rd", g);
        do_req(2, 1'b1, 16'h0201, d15, 16, d15, 1'b1, 1'b0, "w15_wr", g);
        do_req(2, 1'b0, 16'h0201, 16'h0000, 16, d15, 1'b1, 1'b0, "w15_rd", g);
    endtask

    task automatic test_small_depth();
        logic [15:0] g;
        logic [15:0] d;
        d = 16'($urandom);
        do_req(3, 1'b1, 16'h0007, d, 2, d, 1'b1, 1'b0, "small_wr", g);
        do_req(3, 1'b1, 16'h0017, 16'hFFFF, 2, 16'hFFFF, 1'b0, 1'b1, "small_oor_wr", g);
        do_req(3, 1'b0, 16'h0017, 16'h0000, 2, 16'h0000, 1'b1, 1'b1, "small_oor_rd", g);
        do_req(3, 1'b0, 16'h0007, 16'h0000, 2, d, 1'b1, 1'b0, "small_rd", g);
    endtask

    task automatic test_reset_mid_access();
        logic [15:0] g;
        bit acc;
        op0(1'b1, 16'h0040, 16'h0F0F, "mid_preload", g);
        ram_rw[0] = 1'b1;
        ram_address[0] = 16'h0040;
        ram_data[0] = 16'h1234;
        req_valid[0] = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = (req_ready[0] === 1'b1);
            @(posedge clk);
            #1;
        end
        req_valid[0] = 1'b0;
        // Now in the first ACCESS cycle of the 0x1234 write.
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_outputs: valid=%b ready=%b want 0/0",
                         rsp_valid[0], req_ready[0]);
            end
        end
        release_reset();
        checks++;
        if (rsp_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_after_reset_valid: got %b want 0", rsp_valid[0]);
        end
        op0(1'b0, 16'h0040, 16'h0000, "mid_rd_0040", g);
        checks++;
        if (g === 16'h1234) begin
            errors++;
            $display("FAIL mid_dropped_write: got %h want anything but 1234", g);
        end
    endtask

`ifdef RAM_CLEAR_ON_RESET_EN
    task automatic test_clear();
        logic [15:0] g;
        for (int k = 0; k < 16; k++) do_req(3, 1'b1, 16'(k), 16'hFFFF, 2, 16'hFFFF, 1'b1, 1'b0, "clr_fill", g);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        release_reset();
        for (int k = 0; k < 16; k++) do_req(3, 1'b0, 16'(k), 16'h0000, 2, 16'h0000, 1'b1, 1'b0, "clr_rd", g);
    endtask
`endif

    initial begin
        for (int i = 0; i < 4; i++) begin
            req_valid[i] = 1'b0;
            ram_rw[i] = 1'b0;
            ram_address[i] = 16'h0000;
            ram_data[i] = 16'h0000;
        end
        test_reset();
        test_write_read();
        test_back_to_back();
        test_out_of_range();
        test_random();
        test_wait_states();
        test_small_depth();
        test_reset_mid_access();
`ifdef RAM_CLEAR_ON_RESET_EN
        test_clear();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
